// File: rtl/median_3x3_if.sv
`default_nettype none
// ============================================================================
// Module      : median_3x3_if
// Description : Window/result bundle for the 3x3 median filter.
//               master : window producer (drives valid_in, p00..p22;
//                        observes median_out, valid_out)
//               slave  : filter core (the reverse directions)
//               With MEDIAN_MINMAX_EN defined the bundle also carries
//               min_out / max_out of the same window.
// Revision    : 1.0 - initial release
// ============================================================================
interface median_3x3_if #(
   parameter int WIDTH = 8
);
   logic             valid_in;
   logic [WIDTH-1:0] p00, p01, p02;
   logic [WIDTH-1:0] p10, p11, p12;
   logic [WIDTH-1:0] p20, p21, p22;
   logic [WIDTH-1:0] median_out;
   logic             valid_out;
`ifdef MEDIAN_MINMAX_EN
   logic [WIDTH-1:0] min_out;
   logic [WIDTH-1:0] max_out;
`endif

   modport master (
      output valid_in,
      output p00, p01, p02, p10, p11, p12, p20, p21, p22,
      input  median_out,
`ifdef MEDIAN_MINMAX_EN
      input  min_out,
      input  max_out,
`endif
      input  valid_out
   );

   modport slave (
      input  valid_in,
      input  p00, p01, p02, p10, p11, p12, p20, p21, p22,
      output median_out,
`ifdef MEDIAN_MINMAX_EN
      output min_out,
      output max_out,
`endif
      output valid_out
   );
endinterface
`default_nettype wire

// File: rtl/median_3x3.sv
`default_nettype none
// ============================================================================
// Module      : median_3x3
// Description : Three-stage pipelined 3x3 median filter, one window per clock.
//               Stage 1 sorts each row, stage 2 reduces to A = max(row lo),
//               B = med(row mid), C = min(row hi), stage 3 outputs
//               median(A, B, C). Latency is 3 clocks, no backpressure.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset (clears whole pipeline)
//               bus  - median_3x3_if.slave: valid_in, p00..p22 in;
//                      median_out, valid_out (and min_out/max_out) out
// Options     : MEDIAN_MINMAX_EN - also output window min and max, aligned
//               with median_out.
// Revision    : 1.0 - initial release
// ============================================================================
module median_3x3 #(
   parameter int WIDTH = 8
) (
   input  wire logic       clk,
   input  wire logic       rst,
   median_3x3_if.slave     bus
);

   function automatic logic [WIDTH-1:0] f_min(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [WIDTH-1:0] f_max(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      return (a < b) ? b : a;
   endfunction

   function automatic logic [WIDTH-1:0] f_med3(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
      return f_max(f_min(a, b), f_min(f_max(a, b), c));
   endfunction

   // ------------------------------------------------------------------
   // Window as a row/column array
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] w_pix [3][3];

   assign w_pix[0][0] = bus.p00;
   assign w_pix[0][1] = bus.p01;
   assign w_pix[0][2] = bus.p02;
   assign w_pix[1][0] = bus.p10;
   assign w_pix[1][1] = bus.p11;
   assign w_pix[1][2] = bus.p12;
   assign w_pix[2][0] = bus.p20;
   assign w_pix[2][1] = bus.p21;
   assign w_pix[2][2] = bus.p22;

   // ------------------------------------------------------------------
   // Stage 1: per-row 3-comparator sort network
   //   compare-swap (0,1), then (1,2), then (0,1) again
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] w_lo  [3];
   logic [WIDTH-1:0] w_mid [3];
   logic [WIDTH-1:0] w_hi  [3];

   always_comb begin
      logic [WIDTH-1:0] t_a, t_b, t_c;
      for (int r = 0; r < 3; r++) begin
         t_a = f_min(w_pix[r][0], w_pix[r][1]);
         t_b = f_max(w_pix[r][0], w_pix[r][1]);
         t_c = f_max(t_b, w_pix[r][2]);
         t_b = f_min(t_b, w_pix[r][2]);
         w_lo[r]  = f_min(t_a, t_b);
         w_mid[r] = f_max(t_a, t_b);
         w_hi[r]  = t_c;
      end
   end

   logic [WIDTH-1:0] r_lo  [3];
   logic [WIDTH-1:0] r_mid [3];
   logic [WIDTH-1:0] r_hi  [3];
   logic [2:0]       r_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            r_lo[r]  <= '0;
            r_mid[r] <= '0;
            r_hi[r]  <= '0;
         end
         r_vld <= '0;
      end else begin
         for (int r = 0; r < 3; r++) begin
            r_lo[r]  <= w_lo[r];
            r_mid[r] <= w_mid[r];
            r_hi[r]  <= w_hi[r];
         end
         r_vld <= {r_vld[1:0], bus.valid_in};
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: after row sorting the median must lie between the largest
   // row minimum and the smallest row maximum; the three candidates are
   // A, B and C, and the median of the window is their median.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] r_a, r_b, r_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a <= '0;
         r_b <= '0;
         r_c <= '0;
      end else begin
         r_a <= f_max(f_max(r_lo[0], r_lo[1]), r_lo[2]);
         r_b <= f_med3(r_mid[0], r_mid[1], r_mid[2]);
         r_c <= f_min(f_min(r_hi[0], r_hi[1]), r_hi[2]);
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: final median
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] r_med;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_med <= '0;
      end else begin
         r_med <= f_med3(r_a, r_b, r_c);
      end
   end

   assign bus.median_out = r_med;
   assign bus.valid_out  = r_vld[2];

`ifdef MEDIAN_MINMAX_EN
   // Window extremes: overall min is the smallest row minimum, overall max
   // the largest row maximum. Extra register keeps them aligned with r_med.
   logic [WIDTH-1:0] r_mn2, r_mx2;
   logic [WIDTH-1:0] r_mn3, r_mx3;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mn2 <= '0;
         r_mx2 <= '0;
         r_mn3 <= '0;
         r_mx3 <= '0;
      end else begin
         r_mn2 <= f_min(f_min(r_lo[0], r_lo[1]), r_lo[2]);
         r_mx2 <= f_max(f_max(r_hi[0], r_hi[1]), r_hi[2]);
         r_mn3 <= r_mn2;
         r_mx3 <= r_mx2;
      end
   end

   assign bus.min_out = r_mn3;
   assign bus.max_out = r_mx3;
`endif

endmodule
`default_nettype wire

// File: tb/tb_median_3x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_median_3x3
// Description : Self-checking bench for median_3x3. Expected results come
//               from a reference that ranks all nine pixels directly and a
//               per-cycle history of valid/reset used to predict valid_out
//               three cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_median_3x3;

   localparam int W     = 8;
   localparam int HMAX  = 1024;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   median_3x3_if #(.WIDTH(W)) bus ();

   median_3x3 #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bit         h_v   [HMAX];
   bit         h_r   [HMAX];
   logic [7:0] h_med [HMAX];
   logic [7:0] h_min [HMAX];
   logic [7:0] h_max [HMAX];

   logic [7:0] win [9];

   // Median = value whose rank window covers position 5 of the sorted multiset
   function automatic logic [7:0] ref_med(input logic [7:0] w [9]);
      logic [7:0] res;
      res = 8'd0;
      for (int i = 0; i < 9; i++) begin
         int lt, le;
         lt = 0;
         le = 0;
         for (int j = 0; j < 9; j++) begin
            if (w[j] <  w[i]) lt++;
            if (w[j] <= w[i]) le++;
         end
         if (lt <= 4 && le >= 5) res = w[i];
      end
      return res;
   endfunction

   function automatic logic [7:0] ref_min(input logic [7:0] w [9]);
      logic [7:0] m;
      m = w[0];
      for (int i = 1; i < 9; i++) if (w[i] < m) m = w[i];
      return m;
   endfunction

   function automatic logic [7:0] ref_max(input logic [7:0] w [9]);
      logic [7:0] m;
      m = w[0];
      for (int i = 1; i < 9; i++) if (w[i] > m) m = w[i];
      return m;
   endfunction

   task automatic check();
      bit ev;
      int s;
      s  = cyc - 3;
      ev = (s >= 0) && h_v[s] && !h_r[s] && !h_r[s+1] && !h_r[s+2];

      total++;
      assert (bus.valid_out === ev) else begin
         bad++;
         $error("FAIL valid_out cyc=%0d got=%b exp=%b", cyc, bus.valid_out, ev);
      end

      if (h_r[cyc-1]) begin
         total++;
         assert (bus.median_out === 8'd0) else begin
            bad++;
            $error("FAIL rst_median cyc=%0d got=%0d exp=0", cyc, bus.median_out);
         end
`ifdef MEDIAN_MINMAX_EN
         total++;
         assert (bus.min_out === 8'd0 && bus.max_out === 8'd0) else begin
            bad++;
            $error("FAIL rst_minmax cyc=%0d got=%0d/%0d exp=0/0", cyc, bus.min_out, bus.max_out);
         end
`endif
      end

      if (ev) begin
         total++;
         assert (bus.median_out === h_med[s]) else begin
            bad++;
            $error("FAIL median cyc=%0d got=%0d exp=%0d", cyc, bus.median_out, h_med[s]);
         end
`ifdef MEDIAN_MINMAX_EN
         total++;
         assert (bus.min_out === h_min[s]) else begin
            bad++;
            $error("FAIL min cyc=%0d got=%0d exp=%0d", cyc, bus.min_out, h_min[s]);
         end
         total++;
         assert (bus.max_out === h_max[s]) else begin
            bad++;
            $error("FAIL max cyc=%0d got=%0d exp=%0d", cyc, bus.max_out, h_max[s]);
         end
`endif
      end
   endtask

   // Present win with the given valid/reset for one cycle, then check outputs
   task automatic apply(input bit v, input bit r);
      bus.valid_in = v;
      rst          = r;
      bus.p00 = win[0]; bus.p01 = win[1]; bus.p02 = win[2];
      bus.p10 = win[3]; bus.p11 = win[4]; bus.p12 = win[5];
      bus.p20 = win[6]; bus.p21 = win[7]; bus.p22 = win[8];
      h_v[cyc]   = v;
      h_r[cyc]   = r;
      h_med[cyc] = ref_med(win);
      h_min[cyc] = ref_min(win);
      h_max[cyc] = ref_max(win);
      @(posedge clk);
      #1;
      cyc++;
      check();
   endtask

   task automatic rand_win();
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 9; i++)
         win[i] = narrow ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         rand_win();
         apply(1'b0, 1'b0);
      end
   endtask

   initial begin
      bit gap [5];

      for (int i = 0; i < 9; i++) win[i] = 8'd0;

      // Reset
      apply(1'b0, 1'b1);
      apply(1'b1, 1'b1);
      apply(1'b0, 1'b1);
      idle(2);

      // Descending window, single valid cycle
      win = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      apply(1'b1, 1'b0);
      idle(4);

      // Directed boundary windows, back to back
      for (int i = 0; i < 9; i++) win[i] = 8'd200;
      apply(1'b1, 1'b0);
      win = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0};
      apply(1'b1, 1'b0);
      win = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255};
      apply(1'b1, 1'b0);
      win = '{8'd10, 8'd12, 8'd11, 8'd13, 8'd255, 8'd14, 8'd10, 8'd12, 8'd11};
      apply(1'b1, 1'b0);
      idle(4);

      // Streaming random windows
      for (int i = 0; i < 100; i++) begin
         rand_win();
         apply(1'b1, 1'b0);
      end
      idle(4);

      // Reset with two windows in flight, then recovery
      rand_win(); apply(1'b1, 1'b0);
      rand_win(); apply(1'b1, 1'b0);
      rand_win(); apply(1'b1, 1'b1);
      idle(4);
      rand_win(); apply(1'b1, 1'b0);
      idle(4);

      // Gapped valid pattern
      gap = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rand_win();
         apply(gap[i], 1'b0);
      end
      idle(4);

      // Mixed random valid with occasional reset
      for (int i = 0; i < 80; i++) begin
         rand_win();
         apply(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      end
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
